// File: rtl/logic_unit_pkg.sv
// Shared definitions for the sequential logic unit: op encodings and FSM states.
// Optional feature macro used by this block: LOGIC_UNIT_POPCOUNT_EN.
package logic_unit_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_BUF  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/logic_lane.sv
// Combinational LANE-wide gate slice: applies one op to a pair of operand slices.
module logic_lane
    import logic_unit_pkg::*;
#(
    parameter int LANE = 1
) (
    input  logic [2:0]      op,
    input  logic [LANE-1:0] a_slice,
    input  logic [LANE-1:0] b_slice,
    output logic [LANE-1:0] y_slice
);

    always_comb begin
        // NOTE: default assignment first so no path through the case can infer a latch.
        y_slice = a_slice;
        case (op)
            OP_AND:  y_slice = a_slice & b_slice;
            OP_OR:   y_slice = a_slice | b_slice;
            OP_NOT:  y_slice = ~a_slice;
            OP_NAND: y_slice = ~(a_slice & b_slice);
            OP_NOR:  y_slice = ~(a_slice | b_slice);
            OP_XOR:  y_slice = a_slice ^ b_slice;
            OP_XNOR: y_slice = ~(a_slice ^ b_slice);
            default: y_slice = a_slice;
        endcase
    end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle gate unit: processes LANE bits per clock under start/busy/done.
// Define LOGIC_UNIT_POPCOUNT_EN to add the popcount output and its accumulator.
module logic_unit_seq
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANE  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [2:0]                 op,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           result,
    output logic                       zero,
    output logic                       parity
`ifdef LOGIC_UNIT_POPCOUNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] popcount
`endif
);

    localparam int N  = WIDTH / LANE;
    localparam int CW = $clog2(N + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             parity_q, parity_d;
    logic [LANE-1:0]  y_slice;

    logic_lane #(.LANE(LANE)) u_lane (
        .op      (op_q),
        .a_slice (a_q[LANE-1:0]),
        .b_slice (b_q[LANE-1:0]),
        .y_slice (y_slice)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;
        zero_d   = zero_q;
        parity_d = parity_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Slices enter at the top so slice 0 ends up in the LSBs after N shifts.
                a_d   = a_q >> LANE;
                b_d   = b_q >> LANE;
                res_d = (res_q >> LANE) | (WIDTH'(y_slice) << (WIDTH - LANE));
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d   = 1'b1;
                result_d = res_q;
                zero_d   = (res_q == '0);
                parity_d = ^res_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Working registers are reset too, so an aborted run leaves no stale state behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            parity_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            parity_q <= parity_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign zero   = zero_q;
    assign parity = parity_q;

`ifdef LOGIC_UNIT_POPCOUNT_EN
    localparam int PW = $clog2(WIDTH + 1);

    logic [PW-1:0] slice_ones;
    logic [PW-1:0] pc_acc_q, pc_acc_d;
    logic [PW-1:0] popcount_q, popcount_d;

    always_comb begin
        slice_ones = '0;
        for (int i = 0; i < LANE; i++) begin
            slice_ones = slice_ones + PW'(y_slice[i]);
        end
    end

    always_comb begin
        pc_acc_d   = pc_acc_q;
        popcount_d = popcount_q;
        unique case (state_q)
            ST_IDLE: if (start) pc_acc_d = '0;
            ST_RUN:  pc_acc_d = pc_acc_q + slice_ones;
            ST_DONE: popcount_d = pc_acc_q;
            default: pc_acc_d = pc_acc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_acc_q   <= '0;
            popcount_q <= '0;
        end else begin
            pc_acc_q   <= pc_acc_d;
            popcount_q <= popcount_d;
        end
    end

    assign popcount = popcount_q;
`endif

endmodule

// File: tb/tb_logic_unit_seq.sv
// Scoreboard bench for logic_unit_seq: LANE=1 and LANE=4 instances share stimulus,
// a word-level model predicts acceptance, result and completion cycle per instance.
module tb_logic_unit_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;

    logic       busy_w   [2];
    logic       done_w   [2];
    logic [7:0] res_w    [2];
    logic       zero_w   [2];
    logic       par_w    [2];
`ifdef LOGIC_UNIT_POPCOUNT_EN
    logic [3:0] pc_w     [2];
`endif

    logic_unit_seq #(.WIDTH(8), .LANE(1)) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy_w[0]),
        .done   (done_w[0]),
        .result (res_w[0]),
        .zero   (zero_w[0]),
        .parity (par_w[0])
`ifdef LOGIC_UNIT_POPCOUNT_EN
        ,
        .popcount (pc_w[0])
`endif
    );

    logic_unit_seq #(.WIDTH(8), .LANE(4)) u_dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy_w[1]),
        .done   (done_w[1]),
        .result (res_w[1]),
        .zero   (zero_w[1]),
        .parity (par_w[1])
`ifdef LOGIC_UNIT_POPCOUNT_EN
        ,
        .popcount (pc_w[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        int         due;
    } exp_t;

    exp_t       q [2][$];
    int         cyc = 0;
    int         ready_at   [2] = '{0, 0};
    int         busy_until [2] = '{-1, -1};
    logic [7:0] held       [2] = '{8'h00, 8'h00};
    int         checks   = 0;
    int         failures = 0;

    function automatic int n_of(input int k);
        return (k == 0) ? 8 : 2;
    endfunction

    function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return ~x;
            3'd3:    return ~(x & y);
            3'd4:    return ~(x | y);
            3'd5:    return x ^ y;
            3'd6:    return ~(x ^ y);
            default: return x;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a unit accepts start when it is idle, i.e. N+2 edges after its last accept.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                ready_at[k]   = 0;
                busy_until[k] = -1;
            end
        end else begin
            cyc = cyc + 1;
            for (int k = 0; k < 2; k++) begin
                if (start && cyc >= ready_at[k]) begin
                    q[k].push_back('{res: ref_op(op, a, b), due: cyc + n_of(k) + 1});
                    ready_at[k]   = cyc + n_of(k) + 2;
                    busy_until[k] = cyc + n_of(k);
                end
            end
        end
    end

    // Monitor: pops on done, otherwise checks held outputs every cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                q[k].delete();
                held[k] = 8'h00;
            end
            if (done_w[k] === 1'b1) begin
                if (q[k].size() == 0) begin
                    check($sformatf("u%0d unexpected_done", k), 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q[k].pop_front();
                    check($sformatf("u%0d done_cycle", k), cyc, e.due);
                    held[k] = e.res;
                end
            end else begin
                check($sformatf("u%0d done_low", k), 32'(done_w[k]), 32'd0);
            end
            while (q[k].size() > 0 && q[k][0].due < cyc) begin
                check($sformatf("u%0d missing_done", k), 32'd0, 32'd1);
                void'(q[k].pop_front());
            end
            check($sformatf("u%0d result", k), 32'(res_w[k]), 32'(held[k]));
            check($sformatf("u%0d zero", k), 32'(zero_w[k]), 32'(held[k] == 8'h00));
            check($sformatf("u%0d parity", k), 32'(par_w[k]), 32'(^held[k]));
            check($sformatf("u%0d busy", k), 32'(busy_w[k]), 32'(rst_n && cyc <= busy_until[k]));
`ifdef LOGIC_UNIT_POPCOUNT_EN
            check($sformatf("u%0d popcount", k), 32'(pc_w[k]), 32'($countones(held[k])));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One start pulse, then scramble inputs so only captured values can matter.
    task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input int gap);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        step();
        start = 1'b0;
        op    = 3'($urandom);
        a     = 8'($urandom);
        b     = 8'($urandom);
        repeat (8 + gap) step();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        a     = 8'h00;
        b     = 8'h00;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        issue(3'd0, 8'hF0, 8'hCC, 1);
        issue(3'd5, 8'hAA, 8'hAA, 1);
        issue(3'd6, 8'hAA, 8'hAA, 1);
        issue(3'd3, 8'h0F, 8'hFF, 1);
        issue(3'd1, 8'h81, 8'h18, 1);
        issue(3'd2, 8'h5A, 8'h00, 1);
        issue(3'd7, 8'h00, 8'hFF, 1);
        issue(3'd4, 8'h00, 8'h00, 1);

        for (int i = 0; i < 24; i++) begin
            issue(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        // start held high while operands keep changing
        start = 1'b1;
        for (int i = 0; i < 25; i++) begin
            op = 3'($urandom);
            a  = 8'($urandom);
            b  = 8'($urandom);
            step();
        end
        start = 1'b0;
        repeat (12) step();

        // reset pulse a few cycles into a run
        start = 1'b1;
        op    = 3'd0;
        a     = 8'hFF;
        b     = 8'h3C;
        step();
        start = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (12) step();

        issue(3'd5, 8'h3C, 8'h0F, 1);
        repeat (15) step();

        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d queue_drained", k), 32'(q[k].size()), 32'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_unit_seq.md
# logic_unit_seq

Parametrised, multi-cycle successor to the combinational two-input gate block. It applies one selected gate operation (AND, OR, NOT, NAND, NOR, XOR, XNOR, BUF) across two WIDTH-bit operands, LANE bits per clock, under a start/busy/done handshake. Completed results are held in an output register with zero and parity flags. It sits in the DDCO datapath exercises as the logic slice feeding later ALU and register-file blocks.

## Interface
- WIDTH, 8, operand/result width; must be a multiple of LANE
- LANE, 1, bits processed per clock; N = WIDTH/LANE processing cycles
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low; the only reset
- start  input  1  request; sampled only in IDLE
- op  input  3  0 AND, 1 OR, 2 NOT a, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 BUF a
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (ignored by NOT/BUF)
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle completion pulse
- result  output  WIDTH  last completed result
- zero  output  1  result == 0
- parity  output  1  XOR-reduction of result
- popcount  output  $clog2(WIDTH+1)  ones in result (only with LOGIC_UNIT_POPCOUNT_EN)

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE with start=1: capture a, b, op into working shift registers; clear lane counter; go to RUN.
- RUN, each cycle:
  - Apply op to the low LANE bits of the working operands.
  - Shift the slice into the top of the working result; shift operands right by LANE.
  - Increment the counter.
  - After the N-th slice, go to DONE.
- DONE: copy the working result to result and update zero/parity (and popcount when enabled); done=1; return to IDLE next cycle.
- start in RUN or DONE is ignored, with no queuing; a, b, op changes after capture have no effect.
- result/flags change only on entry to DONE. They are held through IDLE and the next RUN.
- Counter width: $clog2(N+1). Wrap is impossible because the FSM leaves RUN at N.
- Reset values: state IDLE; busy 0, done 0, result 0, zero 1, parity 0, popcount 0. Working registers are also 0.
- Reset mid-RUN: abort immediately; no done pulse; outputs return to their reset values.

## Timing
- start sampled high at edge E0: busy=1 after E0; RUN spans edges E1..EN; done=1 and result valid after EN+1, for exactly one cycle.
- Start-to-done latency: N+1 clocks. Minimum start-to-start spacing: N+2 clocks (start re-accepted in the cycle after done).
- done and the new result appear in the same cycle.

## Configuration
- LOGIC_UNIT_POPCOUNT_EN defined:
  - popcount port exists.
  - A per-cycle accumulator adds the ones count of each LANE slice during RUN.
  - The total is latched with result in DONE.
- Not defined: the port, accumulator and adder are absent; all other behaviour is identical.

## Structure
- Package logic_unit_pkg: op encoding constants (OP_AND..OP_BUF), state enum (ST_IDLE, ST_RUN, ST_DONE).
- Sub-module logic_lane: combinational, LANE-wide, (op, a_slice, b_slice) → y_slice; one instance.
- Top holds the FSM, counter, shift registers, output register and flag logic.

## Test plan
- WIDTH=8, LANE=1, op=AND, a=8'hF0, b=8'hCC, start pulsed → done 9 cycles later; result=8'hC0, zero=0, parity=0.
- op=XOR, a=b=8'hAA → result=8'h00, zero=1, parity=0; op=XNOR, same operands → 8'hFF, parity=0.
- WIDTH=8, LANE=4, op=NAND, a=8'h0F, b=8'hFF → done 3 cycles after start; result=8'hF0.
- start held high and a changed during RUN → single done pulse; result matches operands captured at E0; next accept only after done.
- rst_n low for one cycle at RUN cycle 4 → busy=0, done never pulses, result=0, zero=1; a fresh start then completes normally.
- With LOGIC_UNIT_POPCOUNT_EN: op=OR, a=8'h81, b=8'h18 → result=8'h99, popcount=4, parity=0.
